// File: rtl/change_dispenser_pkg.sv
// change_pkg: shared types and default constants for the change dispenser.
//   state_t  - handshake FSM states
//   item_t   - hopper selector (PAPER, DIME, NICKEL)
//   pick_item - fixed-priority item selection PAPER > DIME > NICKEL
package change_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_LOW,
      FAULT
   } state_t;

   typedef enum logic [1:0] {
      PAPER,
      DIME,
      NICKEL
   } item_t;

   localparam int unsigned CNT_W_DEF       = 3;
   localparam int unsigned ACK_TIMEOUT_DEF = 15;
   localparam int unsigned TO_W_DEF        = 4;

   // Caller guarantees at least one flag is set; NICKEL is the fallthrough.
   function automatic item_t pick_item(input logic has_p, input logic has_d, input logic has_n);
      item_t sel;
      if (has_p)      sel = PAPER;
      else if (has_d) sel = DIME;
      else            sel = NICKEL;
      if (!has_n && !has_p && !has_d) sel = NICKEL;
      return sel;
   endfunction

endpackage

// File: rtl/change_dispenser_sat_counter.sv
// sat_counter: pending-item counter with saturating clamp.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : items added this cycle (0..3)
//   dec        : one item removed this cycle
//   cnt        : current count
//   ovf        : pulse, high in the cycle the net result was clamped
module sat_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   // Two extra bits hold the worst case max + 3 before clamping.
   localparam int unsigned     SUM_W = CNT_W + 2;
   localparam logic [SUM_W-1:0] MAX  = SUM_W'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0] sum;

   always_comb begin
      sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, inc};
      // Net the decrement before clamping so a simultaneous inc is never lost.
      if (dec && (sum != '0)) sum = sum - 1'b1;
      ovf   = 1'b0;
      cnt_d = sum[CNT_W-1:0];
      if (sum > MAX) begin
         cnt_d = MAX[CNT_W-1:0];
         ovf   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues release/change pulses and drives the paper, nickel
// and dime hoppers one item at a time with a four-phase req/ack handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   R, N1, D1, D2       : single-cycle pulses adding 1 paper, 1 nickel, 1 / 2 dimes
//   paper/nick/dime_ack : hopper acknowledge levels
//   clr_fault           : pulse; clears fault (leaving FAULT) and ovf
//   paper/nick/dime_req : hopper eject requests
//   pend_p/n/d          : pending item counts
//   busy                : FSM not idle
//   fault               : jam detected, sticky until clr_fault
//   ovf                 : a pending counter saturated, sticky until clr_fault
module change_dispenser
   import change_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int unsigned TO_W        = TO_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             R,
   input  logic             N1,
   input  logic             D1,
   input  logic             D2,
   input  logic             paper_ack,
   input  logic             nick_ack,
   input  logic             dime_ack,
   input  logic             clr_fault,
   output logic             paper_req,
   output logic             nick_req,
   output logic             dime_req,
   output logic [CNT_W-1:0] pend_p,
   output logic [CNT_W-1:0] pend_n,
   output logic [CNT_W-1:0] pend_d,
   output logic             busy,
   output logic             fault,
   output logic             ovf
);

   // Timeout fires on the cycle the counter would reach ACK_TIMEOUT.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   state_t          state_q, state_d;
   item_t           sel_q, sel_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            ovf_q, ovf_d;
   logic            dec_p, dec_n, dec_d;
   logic            sat_p, sat_n, sat_d;
   logic            ack_sel;
   logic            any_pend;

   sat_counter #(.CNT_W(CNT_W)) u_cnt_paper (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ({1'b0, R}),
      .dec   (dec_p),
      .cnt   (pend_p),
      .ovf   (sat_p)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_nick (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ({1'b0, N1}),
      .dec   (dec_n),
      .cnt   (pend_n),
      .ovf   (sat_n)
   );

   // D2 weighs two, D1 one: together they add three.
   sat_counter #(.CNT_W(CNT_W)) u_cnt_dime (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ({D2, D1}),
      .dec   (dec_d),
      .cnt   (pend_d),
      .ovf   (sat_d)
   );

   assign any_pend = (pend_p != '0) || (pend_n != '0) || (pend_d != '0);

   // Only the selected hopper's ack is observed.
   always_comb begin
      ack_sel = 1'b0;
      unique case (sel_q)
         PAPER:   ack_sel = paper_ack;
         DIME:    ack_sel = dime_ack;
         NICKEL:  ack_sel = nick_ack;
         default: ack_sel = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      to_d    = to_q;
      dec_p   = 1'b0;
      dec_n   = 1'b0;
      dec_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_pend) begin
               sel_d   = pick_item(pend_p != '0, pend_d != '0, pend_n != '0);
               state_d = REQ;
               to_d    = '0;
            end
         end
         REQ: begin
            if (ack_sel) begin
               state_d = WAIT_LOW;
               to_d    = '0;
            end else begin
               to_d = to_q + 1'b1;
               if (to_q == TO_LAST) state_d = FAULT;
            end
         end
         WAIT_LOW: begin
            if (!ack_sel) begin
               // Item is consumed only once the hopper has released ack.
               case (sel_q)
                  PAPER:   dec_p = 1'b1;
                  DIME:    dec_d = 1'b1;
                  NICKEL:  dec_n = 1'b1;
                  default: ;
               endcase
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
               if (to_q == TO_LAST) state_d = FAULT;
            end
         end
         FAULT: begin
            // The jammed item was never decremented, so it is retried from IDLE.
            if (clr_fault) begin
               state_d = IDLE;
               to_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A fresh saturation in the same cycle as clr_fault keeps ovf set.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_fault) ovf_d = 1'b0;
      if (sat_p || sat_n || sat_d) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= PAPER;
         to_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         to_q    <= to_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      paper_req = (state_q == REQ) && (sel_q == PAPER);
      nick_req  = (state_q == REQ) && (sel_q == NICKEL);
      dime_req  = (state_q == REQ) && (sel_q == DIME);
      busy      = (state_q != IDLE);
      fault     = (state_q == FAULT);
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Hopper acks come either from a model that
// follows each req with one cycle of lag, or from manually driven levels.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       R = 1'b0, N1 = 1'b0, D1 = 1'b0, D2 = 1'b0, clr_fault = 1'b0;
   logic       paper_ack, nick_ack, dime_ack;
   logic       paper_req, nick_req, dime_req;
   logic [2:0] pend_p, pend_n, pend_d;
   logic       busy, fault, ovf;

   logic auto_en = 1'b0;
   logic man_p = 1'b0, man_n = 1'b0, man_d = 1'b0;
   logic auto_p = 1'b0, auto_n = 1'b0, auto_d = 1'b0;
   logic st_p = 1'b0, st_n = 1'b0, st_d = 1'b0;

   assign paper_ack = auto_en ? auto_p : man_p;
   assign nick_ack  = auto_en ? auto_n : man_n;
   assign dime_ack  = auto_en ? auto_d : man_d;

   int total = 0;
   int bad   = 0;

   // Service log: 0 paper, 1 dime, 2 nickel, one entry per req rising edge.
   int   order[$];
   int   rise_p = 0, rise_n = 0, rise_d = 0, hi_p = 0;
   logic prev_p = 1'b0, prev_n = 1'b0, prev_d = 1'b0;

   change_dispenser dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .R         (R),
      .N1        (N1),
      .D1        (D1),
      .D2        (D2),
      .paper_ack (paper_ack),
      .nick_ack  (nick_ack),
      .dime_ack  (dime_ack),
      .clr_fault (clr_fault),
      .paper_req (paper_req),
      .nick_req  (nick_req),
      .dime_req  (dime_req),
      .pend_p    (pend_p),
      .pend_n    (pend_n),
      .pend_d    (pend_d),
      .busy      (busy),
      .fault     (fault),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Hopper model: ack level equals the req level of the previous cycle.
   always begin
      @(negedge clk);
      st_p = paper_req;
      st_n = nick_req;
      st_d = dime_req;
      @(posedge clk);
      #2;
      auto_p = st_p;
      auto_n = st_n;
      auto_d = st_d;
   end

   always @(negedge clk) begin
      if (paper_req && !prev_p) begin rise_p++; order.push_back(0); end
      if (dime_req && !prev_d)  begin rise_d++; order.push_back(1); end
      if (nick_req && !prev_n)  begin rise_n++; order.push_back(2); end
      if (paper_req) hi_p++;
      prev_p = paper_req;
      prev_n = nick_req;
      prev_d = dime_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic r, input logic n, input logic d1, input logic d2);
      R = r; N1 = n; D1 = d1; D2 = d2;
      tick();
      R = 1'b0; N1 = 1'b0; D1 = 1'b0; D2 = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while ((busy || pend_p != 0 || pend_n != 0 || pend_d != 0) && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (busy || pend_p != 0 || pend_n != 0 || pend_d != 0) begin
         bad++;
         $display("FAIL %s_drain: busy=%b pend=%0d/%0d/%0d after %0d cycles, required idle and empty",
                  name, busy, pend_p, pend_n, pend_d, n);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      total++; if (paper_req !== 1'b0) begin bad++; $display("FAIL rst_paper_req: got %b want 0", paper_req); end
      total++; if (nick_req !== 1'b0) begin bad++; $display("FAIL rst_nick_req: got %b want 0", nick_req); end
      total++; if (dime_req !== 1'b0) begin bad++; $display("FAIL rst_dime_req: got %b want 0", dime_req); end
      total++; if (pend_p !== 3'd0) begin bad++; $display("FAIL rst_pend_p: got %0d want 0", pend_p); end
      total++; if (pend_n !== 3'd0) begin bad++; $display("FAIL rst_pend_n: got %0d want 0", pend_n); end
      total++; if (pend_d !== 3'd0) begin bad++; $display("FAIL rst_pend_d: got %0d want 0", pend_d); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_after: busy got %b want 0", busy); end
   endtask

   task automatic test_single_paper();
      int b_p, b_n, b_d, b_hi;
      auto_en = 1'b1;
      b_p = rise_p; b_n = rise_n; b_d = rise_d; b_hi = hi_p;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (pend_p !== 3'd1) begin bad++; $display("FAIL single_pend_up: got %0d want 1", pend_p); end
      total++; if (paper_req !== 1'b0) begin bad++; $display("FAIL single_req_early: got %b want 0", paper_req); end
      tick();
      total++; if (paper_req !== 1'b1) begin bad++; $display("FAIL single_req_rise: got %b want 1", paper_req); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
      wait_done(40, "single");
      total++; if (hi_p - b_hi !== 2) begin bad++; $display("FAIL single_req_len: got %0d want 2", hi_p - b_hi); end
      total++; if (rise_p - b_p !== 1) begin bad++; $display("FAIL single_paper_cnt: got %0d want 1", rise_p - b_p); end
      total++; if (rise_n - b_n + rise_d - b_d !== 0) begin bad++; $display("FAIL single_other_req: got %0d want 0", rise_n - b_n + rise_d - b_d); end
   endtask

   task automatic test_sequence();
      int base;
      int exp_ord[5] = '{0, 0, 1, 1, 2};
      auto_en = 1'b0;
      base = order.size();
      // Park the FSM on a paper request so the next three pulses queue up.
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (paper_req !== 1'b1) begin bad++; $display("FAIL seq_park: paper_req got %b want 1", paper_req); end
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (pend_d !== 3'd2) begin bad++; $display("FAIL seq_pend_d: got %0d want 2", pend_d); end
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (pend_p !== 3'd2) begin bad++; $display("FAIL seq_pend_p: got %0d want 2", pend_p); end
      total++; if (pend_n !== 3'd1) begin bad++; $display("FAIL seq_pend_n: got %0d want 1", pend_n); end
      auto_en = 1'b1;
      wait_done(200, "seq");
      total++; if (order.size() - base !== 5) begin bad++; $display("FAIL seq_count: got %0d want 5", order.size() - base); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (base + i >= order.size()) begin
            bad++; $display("FAIL seq_order[%0d]: got none want %0d", i, exp_ord[i]);
         end else if (order[base + i] !== exp_ord[i]) begin
            bad++; $display("FAIL seq_order[%0d]: got %0d want %0d", i, order[base + i], exp_ord[i]);
         end
      end
   endtask

   task automatic test_overflow_fault();
      int n = 0;
      auto_en = 1'b0;
      man_d = 1'b0;
      pulse(1'b0, 1'b0, 1'b1, 1'b1);
      total++; if (pend_d !== 3'd3) begin bad++; $display("FAIL ovf_d1d2: got %0d want 3", pend_d); end
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (pend_d !== 3'd7 || ovf !== 1'b0) begin bad++; $display("FAIL ovf_at_max: pend_d=%0d ovf=%b want 7/0", pend_d, ovf); end
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (pend_d !== 3'd7 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_clamp: pend_d=%0d ovf=%b want 7/1", pend_d, ovf); end
      total++; if (dime_req !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL ovf_req: dime_req=%b fault=%b want 1/0", dime_req, fault); end
      // REQ entered two edges ago; 15 REQ cycles end 13 edges from here.
      while (!fault && n < 30) begin tick(); n++; end
      total++; if (n !== 13) begin bad++; $display("FAIL fault_timing: got %0d cycles want 13", n); end
      total++; if (dime_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fault_outputs: dime_req=%b busy=%b want 0/1", dime_req, busy); end
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (pend_p !== 3'd1 || fault !== 1'b1 || paper_req !== 1'b0) begin
         bad++; $display("FAIL fault_accum: pend_p=%0d fault=%b paper_req=%b want 1/1/0", pend_p, fault, paper_req);
      end
   endtask

   task automatic test_clear_retry();
      int b_p, b_d;
      auto_en = 1'b1;
      b_p = rise_p; b_d = rise_d;
      clr_fault = 1'b1;
      tick();
      clr_fault = 1'b0;
      total++; if (fault !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL clr_flags: fault=%b ovf=%b busy=%b want 0/0/0", fault, ovf, busy);
      end
      wait_done(200, "retry");
      total++; if (rise_d - b_d !== 7) begin bad++; $display("FAIL retry_dimes: got %0d want 7", rise_d - b_d); end
      total++; if (rise_p - b_p !== 1) begin bad++; $display("FAIL retry_paper: got %0d want 1", rise_p - b_p); end
   endtask

   task automatic test_same_cycle();
      auto_en = 1'b0;
      man_n = 1'b0;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (nick_req !== 1'b1) begin bad++; $display("FAIL same_req1: got %b want 1", nick_req); end
      man_n = 1'b1;
      tick();
      total++; if (nick_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL same_wait_low: req=%b busy=%b want 0/1", nick_req, busy); end
      man_n = 1'b0;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (pend_n !== 3'd1 || busy !== 1'b0) begin bad++; $display("FAIL same_net: pend_n=%0d busy=%b want 1/0", pend_n, busy); end
      tick();
      total++; if (nick_req !== 1'b1) begin bad++; $display("FAIL same_req2: got %b want 1", nick_req); end
      man_n = 1'b1;
      tick();
      man_n = 1'b0;
      tick();
      total++; if (pend_n !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL same_done: pend_n=%0d busy=%b want 0/0", pend_n, busy); end
   endtask

   task automatic test_reset_mid();
      auto_en = 1'b0;
      man_n = 1'b0;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (nick_req !== 1'b1) begin bad++; $display("FAIL rmid_req: got %b want 1", nick_req); end
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      total++; if (nick_req !== 1'b0) begin bad++; $display("FAIL rmid_req_drop: got %b want 0", nick_req); end
      total++; if (pend_n !== 3'd0 || pend_d !== 3'd0) begin bad++; $display("FAIL rmid_pend: n=%0d d=%0d want 0/0", pend_n, pend_d); end
      #3 rst_n = 1'b1;
      tick();
      tick();
      total++; if (busy !== 1'b0 || nick_req !== 1'b0) begin bad++; $display("FAIL rmid_idle: busy=%b req=%b want 0/0", busy, nick_req); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single_paper();
      test_sequence();
      test_overflow_fault();
      test_clear_retry();
      test_same_cycle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
